// File: rtl/cmd_dispatch_if.sv
// rtl/cmd_dispatch_if.sv - SPI slave command/response handshake bundle for cmd_dispatch
interface cmd_dispatch_if;
   logic [15:0] cmd_rcvd;
   logic        cmd_rdy;
   logic        rsp_rdy;
   logic [15:0] tx_data;
   logic        wrt;

   // SPI slave side: supplies commands and tx buffer status, accepts responses
   modport master (
      output cmd_rcvd, cmd_rdy, rsp_rdy,
      input  tx_data, wrt
   );

   // Dispatcher side
   modport slave (
      input  cmd_rcvd, cmd_rdy, rsp_rdy,
      output tx_data, wrt
   );
endinterface

// File: rtl/cmd_dispatch.sv
// rtl/cmd_dispatch.sv - SPI command decoder, 8x8 config regs and capture RAM dump engine; optional watchdog via DUMP_TIMEOUT_EN
module cmd_dispatch #(
   parameter int RAM_AW      = 9,
   parameter int RAM_LAT     = 1,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   cmd_dispatch_if.slave     spi,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_rd_en,
   input  logic [15:0]       ram_rdata,
   output logic [63:0]       cfg_regs,
   output logic              dump_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_DUMP_RD,
      S_DUMP_DATA,
      S_DUMP_TX
   } state_t;

   localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

   state_t      state;
   logic        cmd_rdy_q;
   logic        pend;        // command accepted but not yet executed
   logic [15:0] cmd_q;
   logic [8:0]  remaining;   // words left in the running dump (1..256)
   logic [1:0]  lat_cnt;
   logic [15:0] dump_word;

`ifdef DUMP_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] to_cnt;
`endif

   logic        new_cmd;
   logic [15:0] cmd_word;
   logic [3:0]  op;
   logic [2:0]  wa;
   logic [7:0]  wd;
   logic        unused_bit;

   // Rising cmd_rdy marks a fresh command; a deferred one is replayed from cmd_q
   always_comb begin
      new_cmd  = spi.cmd_rdy & ~cmd_rdy_q;
      cmd_word = pend ? cmd_q : spi.cmd_rcvd;
      op       = cmd_word[15:12];
      wa       = cmd_word[10:8];
      wd       = cmd_word[7:0];
   end

   assign unused_bit = cmd_word[11];

   // Main control: command decode, register file, dump sequencing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cmd_rdy_q   <= 1'b0;
         pend        <= 1'b0;
         cmd_q       <= '0;
         remaining   <= '0;
         lat_cnt     <= '0;
         dump_word   <= '0;
         spi.tx_data <= '0;
         spi.wrt     <= 1'b0;
         ram_addr    <= '0;
         ram_rd_en   <= 1'b0;
         cfg_regs    <= '0;
         dump_busy   <= 1'b0;
`ifdef DUMP_TIMEOUT_EN
         to_cnt      <= '0;
`endif
      end else begin
         cmd_rdy_q <= spi.cmd_rdy;
         spi.wrt   <= 1'b0;
         ram_rd_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (new_cmd || pend) begin
                  cmd_q <= cmd_word;
                  if (spi.wrt) begin
                     // A strobe is on the wire this cycle; hold off one cycle
                     pend <= 1'b1;
                  end else begin
                     pend  <= 1'b0;
                     state <= S_EXEC;
                     case (op)
                        4'h1: begin
                           cfg_regs[{wa, 3'b000} +: 8] <= wd;
                           spi.tx_data <= 16'hA5A5;
                           spi.wrt     <= 1'b1;
                        end
                        4'h2: begin
                           spi.tx_data <= {8'h00, cfg_regs[{wa, 3'b000} +: 8]};
                           spi.wrt     <= 1'b1;
                        end
                        4'h3: ;
                        default: begin
                           spi.tx_data <= 16'hEEEE;
                           spi.wrt     <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            S_EXEC: begin
               if (cmd_q[15:12] == 4'h3) begin
                  ram_addr  <= cfg_regs[48 +: RAM_AW];
                  ram_rd_en <= 1'b1;
                  remaining <= (cmd_q[7:0] == 8'd0) ? 9'd256 : {1'b0, cmd_q[7:0]};
                  dump_busy <= 1'b1;
                  state     <= S_DUMP_RD;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: begin
               if (new_cmd) begin
                  // Abort: drop any read in flight and replay the command from IDLE
                  state     <= S_IDLE;
                  dump_busy <= 1'b0;
                  pend      <= 1'b1;
                  cmd_q     <= spi.cmd_rcvd;
`ifdef DUMP_TIMEOUT_EN
                  to_cnt    <= '0;
`endif
               end else begin
                  case (state)
                     S_DUMP_RD: begin
                        lat_cnt <= '0;
                        state   <= S_DUMP_DATA;
                     end
                     S_DUMP_DATA: begin
                        if (lat_cnt == LAT_LAST) begin
                           dump_word <= ram_rdata;
                           state     <= S_DUMP_TX;
                        end else begin
                           lat_cnt <= lat_cnt + 2'd1;
                        end
                     end
                     S_DUMP_TX: begin
                        if (!spi.rsp_rdy) begin
                           spi.wrt     <= 1'b1;
                           spi.tx_data <= dump_word;
                           remaining   <= remaining - 9'd1;
                           ram_addr    <= ram_addr + 1'b1;
`ifdef DUMP_TIMEOUT_EN
                           to_cnt      <= '0;
`endif
                           if (remaining == 9'd1) begin
                              state     <= S_IDLE;
                              dump_busy <= 1'b0;
                           end else begin
                              ram_rd_en <= 1'b1;
                              state     <= S_DUMP_RD;
                           end
                        end
`ifdef DUMP_TIMEOUT_EN
                        else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                           spi.wrt      <= 1'b1;
                           spi.tx_data  <= 16'hDEAD;
                           cfg_regs[47] <= 1'b1;
                           state        <= S_IDLE;
                           dump_busy    <= 1'b0;
                           to_cnt       <= '0;
                        end else begin
                           to_cnt <= to_cnt + 1'b1;
                        end
`endif
                     end
                     default: state <= S_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_dispatch.sv
// tb/tb_cmd_dispatch.sv - directed self-checking bench for cmd_dispatch
module tb_cmd_dispatch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [8:0]  ram_addr;
   logic        ram_rd_en;
   logic [15:0] ram_rdata = 16'h0000;
   logic [63:0] cfg_regs;
   logic        dump_busy;

   cmd_dispatch_if spi();

   cmd_dispatch #(.RAM_AW(9), .RAM_LAT(1), .TIMEOUT_CYC(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi       (spi),
      .ram_addr  (ram_addr),
      .ram_rd_en (ram_rd_en),
      .ram_rdata (ram_rdata),
      .cfg_regs  (cfg_regs),
      .dump_busy (dump_busy)
   );

`ifdef DUMP_TIMEOUT_EN
   localparam int HOLD = 10;
`else
   localparam int HOLD = 50;
`endif

   always #5 clk = ~clk;

   // Capture RAM: RAM[i] = i ^ 8000, one cycle read latency
   always @(posedge clk) if (ram_rd_en) ram_rdata <= {7'b0, ram_addr} ^ 16'h8000;

   int          n_checks = 0;
   int          n_fail = 0;
   int          ncyc = 0;
   int          b2b = 0;
   logic        prev_wrt = 1'b0;
   int          wrt_cyc[$];
   logic [15:0] wrt_dat[$];
   logic [8:0]  rd_addr[$];
   logic [63:0] exp_cfg;

   // Observe DUT outputs on the falling edge
   always @(negedge clk) begin
      if (spi.wrt) begin
         wrt_cyc.push_back(ncyc);
         wrt_dat.push_back(spi.tx_data);
      end
      if (ram_rd_en) rd_addr.push_back(ram_addr);
      if (spi.wrt && prev_wrt) b2b++;
      prev_wrt = spi.wrt;
      ncyc = ncyc + 1;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      wrt_cyc.delete();
      wrt_dat.delete();
      rd_addr.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic issue(input logic [15:0] w, output int t0);
      @(negedge clk);
      #1;
      spi.cmd_rcvd = w;
      spi.cmd_rdy  = 1'b1;
      t0 = ncyc;
   endtask

   task automatic release_cmd();
      @(negedge clk);
      #1;
      spi.cmd_rdy = 1'b0;
   endtask

   task automatic wait_wrt(input int n, input int budget, input string tag);
      int i = 0;
      while (wrt_dat.size() < n && i < budget) begin
         @(negedge clk);
         #1;
         i++;
      end
      check_eq(tag, wrt_dat.size(), n);
   endtask

   task automatic do_cmd(input logic [15:0] w, input int hold, input logic [15:0] rsp, input string tag);
      int t0;
      clear_log();
      issue(w, t0);
      idle(hold);
      release_cmd();
      idle(2);
      check_eq({tag, "_cnt"}, wrt_dat.size(), 1);
      if (wrt_dat.size() >= 1) begin
         check_eq({tag, "_cyc"}, wrt_cyc[0], t0);
         check_eq({tag, "_dat"}, wrt_dat[0], rsp);
      end
   endtask

   initial begin
      int t0;
      int t1;
      spi.cmd_rcvd = 16'h0000;
      spi.cmd_rdy  = 1'b0;
      spi.rsp_rdy  = 1'b0;
      idle(3);
      check_eq("rst_tx_data", spi.tx_data, 0);
      check_eq("rst_wrt", spi.wrt, 0);
      check_eq("rst_ram_addr", ram_addr, 0);
      check_eq("rst_ram_rd_en", ram_rd_en, 0);
      check_eq("rst_cfg", cfg_regs, 0);
      check_eq("rst_busy", dump_busy, 0);
      #1 rst_n = 1'b1;
      idle(2);
      exp_cfg = 64'h0;

      do_cmd(16'h135C, 3, 16'hA5A5, "t1_wr");
      exp_cfg[31:24] = 8'h5C;
      check_eq("t1_cfg", cfg_regs, exp_cfg);

      do_cmd(16'h2300, 20, 16'h005C, "t2_rd");

      do_cmd(16'hF000, 3, 16'hEEEE, "t3_nak_f");
      check_eq("t3_cfg_f", cfg_regs, exp_cfg);
      do_cmd(16'h0000, 3, 16'hEEEE, "t3_nak_0");
      check_eq("t3_cfg_0", cfg_regs, exp_cfg);

      do_cmd(16'h16FF, 2, 16'hA5A5, "wr_r6");
      do_cmd(16'h1F01, 2, 16'hA5A5, "wr_r7_b11");
      exp_cfg[55:48] = 8'hFF;
      exp_cfg[63:56] = 8'h01;
      check_eq("cfg_r67", cfg_regs, exp_cfg);

      // Dump of three words starting at 1FF, wrapping to 000
      clear_log();
      spi.rsp_rdy = 1'b0;
      issue(16'h3003, t0);
      idle(2);
      check_eq("t4_busy_mid", dump_busy, 1);
      release_cmd();
      wait_wrt(3, 60, "t4_cnt");
      idle(10);
      check_eq("t4_cnt_after", wrt_dat.size(), 3);
      check_eq("t4_busy_end", dump_busy, 0);
      if (wrt_dat.size() == 3) begin
         check_eq("t4_d0", wrt_dat[0], 16'h81FF);
         check_eq("t4_d1", wrt_dat[1], 16'h8000);
         check_eq("t4_d2", wrt_dat[2], 16'h8001);
         check_eq("t4_first_lat_ok", (wrt_cyc[0] - t0 + 1) >= 3, 1);
      end
      check_eq("t4_rd_cnt", rd_addr.size(), 3);
      if (rd_addr.size() == 3) begin
         check_eq("t4_a0", rd_addr[0], 9'h1FF);
         check_eq("t4_a1", rd_addr[1], 9'h000);
         check_eq("t4_a2", rd_addr[2], 9'h001);
      end

      // Stall after word 1, then abort with a register read
      clear_log();
      issue(16'h3003, t0);
      release_cmd();
      wait_wrt(1, 40, "t5_w1");
      spi.rsp_rdy = 1'b1;
      idle(HOLD);
      check_eq("t5_stall_cnt", wrt_dat.size(), 1);
      check_eq("t5_stall_busy", dump_busy, 1);
      issue(16'h2600, t1);
      release_cmd();
      idle(3);
      check_eq("t5_abort_cnt", wrt_dat.size(), 2);
      if (wrt_dat.size() == 2) begin
         check_eq("t5_rd_dat", wrt_dat[1], 16'h00FF);
         check_eq("t5_rd_cyc", wrt_cyc[1], t1 + 1);
      end
      spi.rsp_rdy = 1'b0;
      idle(20);
      check_eq("t5_no_more", wrt_dat.size(), 2);
      check_eq("t5_busy_end", dump_busy, 0);

`ifdef DUMP_TIMEOUT_EN
      clear_log();
      spi.rsp_rdy = 1'b1;
      issue(16'h3003, t0);
      release_cmd();
      wait_wrt(1, 60, "t6_cnt");
      if (wrt_dat.size() >= 1) begin
         check_eq("t6_dead", wrt_dat[0], 16'hDEAD);
         check_eq("t6_after16", (wrt_cyc[0] - t0) >= 16, 1);
      end
      idle(1);
      exp_cfg[47] = 1'b1;
      check_eq("t6_sticky", cfg_regs, exp_cfg);
      check_eq("t6_busy", dump_busy, 0);
      spi.rsp_rdy = 1'b0;
      do_cmd(16'h1500, 2, 16'hA5A5, "t6_clr");
      exp_cfg[47:40] = 8'h00;
      check_eq("t6_cleared", cfg_regs, exp_cfg);
`endif

      do_cmd(16'h1580, 2, 16'hA5A5, "wr_r5");
      exp_cfg[47:40] = 8'h80;
      do_cmd(16'h2500, 2, 16'h0080, "rd_r5");
      check_eq("cfg_r5", cfg_regs, exp_cfg);

      // Reset in the middle of a stalled dump
      clear_log();
      spi.rsp_rdy = 1'b1;
      issue(16'h3003, t0);
      release_cmd();
      idle(6);
      check_eq("rstm_busy_before", dump_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rstm_tx_data", spi.tx_data, 0);
      check_eq("rstm_ram_addr", ram_addr, 0);
      check_eq("rstm_rd_en", ram_rd_en, 0);
      check_eq("rstm_cfg", cfg_regs, 0);
      check_eq("rstm_busy", dump_busy, 0);
      idle(2);
      #1 rst_n = 1'b1;
      spi.rsp_rdy = 1'b0;
      idle(30);
      check_eq("rstm_no_wrt", wrt_dat.size(), 0);
      check_eq("rstm_busy_after", dump_busy, 0);

      check_eq("no_b2b_wrt", b2b, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1);
   end
endmodule
